// File: rtl/vram_port.sv
// Video RAM port: CPU register window feeding an ordered write queue that drains
// into the backing store during vertical blank (or when forced); pixel reads are combinational.
module vram_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int VRAM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_in,
  output logic [7:0]  data_out,
  input  logic [9:0]  true_line,
  input  logic        cpu_sel,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_reg,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata
);

  localparam int          AW            = (VRAM_BYTES > 1) ? $clog2(VRAM_BYTES) : 1;
  localparam int          PW            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [16:0] VRAM_LIMIT    = 17'(VRAM_BYTES);
  localparam logic [PW:0] FIFO_FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [9:0]  VBLANK_LINE   = 10'd480;

  localparam logic [1:0] REG_ADDR_HI = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  function automatic logic in_store(input logic [15:0] a);
    return {1'b0, a} < VRAM_LIMIT;
  endfunction

  // Column-stride mode steps a full 32-byte row instead of one byte; wraps at 64K.
  function automatic logic [15:0] next_ptr(input logic [15:0] p, input logic stride32);
    return stride32 ? (p + 16'd32) : (p + 16'd1);
  endfunction

  logic [7:0]    store [VRAM_BYTES];
  logic [23:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;
  logic [PW:0]   count;
  logic [15:0]   ptr;
  logic [1:0]    ctrl;
  logic          overflow;

  logic          full;
  logic          empty;
  logic          in_window;
  logic          rd_strobe;
  logic          rd_status;
  logic          data_wr;
  logic          push;
  logic          drop;
  logic          vld_p0;
  logic [15:0]   head_addr_p0;
  logic [7:0]    head_data_p0;
  logic          store_we_p0;
  logic [7:0]    status;
  logic [7:0]    rd_mux;

  assign full      = (count == FIFO_FULL_CNT);
  assign empty     = (count == '0);
  assign in_window = (true_line >= VBLANK_LINE) || ctrl[1];

  assign rd_strobe = cpu_sel && !cpu_we;
  assign rd_status = rd_strobe && (cpu_reg == REG_CTRL);
  assign data_wr   = cpu_sel && cpu_we && (cpu_reg == REG_DATA);

  // A pop frees a slot on the same edge, so a full queue still accepts while draining.
  assign vld_p0 = in_window && !empty;
  assign push   = data_wr && (!full || vld_p0);
  assign drop   = data_wr && full && !vld_p0;

  assign head_addr_p0 = fifo_q[rd_idx][23:8];
  assign head_data_p0 = fifo_q[rd_idx][7:0];
  assign store_we_p0  = vld_p0 && in_store(head_addr_p0) && !reset;

  assign status = {2'b00, ctrl, overflow, in_window, empty, full};

  always_comb begin
    rd_mux = 8'h00;
    case (cpu_reg)
      REG_ADDR_HI: rd_mux = ptr[15:8];
      REG_ADDR_LO: rd_mux = ptr[7:0];
      REG_DATA:    rd_mux = 8'h00;
      REG_CTRL:    rd_mux = status;
      default:     rd_mux = 8'h00;
    endcase
  end

  // Pixel read returns the pre-edge byte; a same-cycle drain write shows up next cycle.
  assign data_out = in_store(addr_in) ? store[addr_in[AW-1:0]] : 8'h00;

  // ---- stage p0: queue head commits to the store ----
  always_ff @(posedge clk) begin
    if (store_we_p0) begin
      store[head_addr_p0[AW-1:0]] <= head_data_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_idx] <= {ptr, cpu_wdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= 16'h0000;
      ctrl      <= 2'b00;
      overflow  <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      count     <= '0;
      cpu_rdata <= 8'h00;
    end else begin
      if (push) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (vld_p0) begin
        rd_idx <= rd_idx + 1'b1;
      end
      case ({push, vld_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (cpu_sel && cpu_we && (cpu_reg == REG_ADDR_HI)) begin
        ptr[15:8] <= cpu_wdata;
      end
      if (cpu_sel && cpu_we && (cpu_reg == REG_ADDR_LO)) begin
        ptr[7:0] <= cpu_wdata;
      end
      if (push) begin
        ptr <= next_ptr(ptr, ctrl[0]);
      end
      if (cpu_sel && cpu_we && (cpu_reg == REG_CTRL)) begin
        ctrl <= cpu_wdata[1:0];
      end

      // Sticky until read; a new drop wins over the clear-on-read.
      if (drop) begin
        overflow <= 1'b1;
      end else if (rd_status) begin
        overflow <= 1'b0;
      end

      if (rd_strobe) begin
        cpu_rdata <= rd_mux;
      end
    end
  end

endmodule

// File: doc/vram_port.md
VRAM_PORT -- requirements
Module: vram_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning CPU write-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter VRAM_BYTES, default 8192, meaning backing-store size; valid addresses are 0..VRAM_BYTES-1.
REQ-003 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port addr_in, input, 16, meaning pixel-processor read address.
REQ-006 SHALL have port data_out, output, 8, meaning read data for addr_in.
REQ-007 SHALL have port true_line, input, 10, meaning raster line, 0..524.
REQ-008 SHALL have port cpu_sel, input, 1, meaning register access strobe, one cycle per access.
REQ-009 SHALL have port cpu_we, input, 1, meaning 1=write, 0=read; qualified by cpu_sel.
REQ-010 SHALL have port cpu_reg, input, 2, meaning register select: 0 ADDR_HI, 1 ADDR_LO, 2 DATA, 3 CTRL/STATUS.
REQ-011 SHALL have port cpu_wdata, input, 8, meaning register write data.
REQ-012 SHALL have port cpu_rdata, output, 8, meaning register read data, registered.

Function
REQ-013 SHALL drive data_out combinationally from addr_in, valid in the same cycle; addr_in >= VRAM_BYTES returns 0x00.
REQ-014 SHALL hold a 16-bit CPU pointer: ADDR_HI write sets bits 15:8, ADDR_LO write sets bits 7:0.
REQ-015 SHALL, on a DATA write, enqueue {pointer, cpu_wdata}, then advance the pointer by 1, or by 32 when CTRL bit0=1, modulo 2^16.
REQ-016 SHALL, on a DATA write with the FIFO full, drop the write, leave the pointer unchanged, and set sticky STATUS bit3 (overflow).
REQ-017 SHALL define the drain window as true_line >= 480 or CTRL bit1 (force) = 1.
REQ-018 SHALL, in the drain window with the FIFO non-empty, pop one entry per cycle and write it to the store on that clock edge.
REQ-019 SHALL discard a popped entry whose address >= VRAM_BYTES, without writing the store.
REQ-020 SHALL, for a write and a read of the same address in one cycle, return the old byte; the new byte appears on data_out from the next cycle.
REQ-021 SHALL, on a simultaneous enqueue and pop, keep the FIFO count unchanged and accept the enqueue even when count=FIFO_DEPTH before the cycle.
REQ-022 SHALL return CTRL/STATUS reads as bit0 full, bit1 empty, bit2 in-window, bit3 overflow, bits5:4 CTRL bits1:0, bits7:6 zero.
REQ-023 SHALL clear the overflow bit on a CTRL/STATUS read; an overflow in the same cycle stays set.
REQ-024 SHALL set CTRL bits1:0 from cpu_wdata[1:0] on a reg-3 write.
REQ-025 SHALL return reads of regs 0/1 as the pointer bytes, and of reg 2 as 0x00.
REQ-026 SHALL update cpu_rdata one cycle after a read strobe and hold it otherwise.
REQ-027 SHALL preserve FIFO order; writes leave the store only through the FIFO.

Reset
REQ-028 SHALL, on reset, clear pointer, CTRL, overflow, FIFO pointers and count (empty=1), and cpu_rdata.
REQ-029 SHALL leave store contents undefined after power-up and unchanged by reset.
REQ-030 SHALL discard queued entries on reset asserted mid-operation, with no partial store write.

Verification
REQ-031 Write ADDR_HI=0x18, ADDR_LO=0x00, DATA=0x5A, true_line=480 -> store[0x1800]=0x5A next cycle; data_out=0x5A at addr_in=0x1800; pointer=0x1801.
REQ-032 CTRL=0x01, pointer=0x1BC0, three DATA writes, true_line=100 -> no store change, STATUS bit1=0; then line 480 -> 0x1BC0/0x1BE0/0x1C00 written on 3 consecutive cycles.
REQ-033 Five DATA writes with FIFO_DEPTH=4 outside window -> 5th dropped, pointer+4, STATUS=0x09; a second STATUS read -> 0x01.
REQ-034 Pointer=0xFFFF, DATA write -> pointer wraps to 0x0000; entry discarded at drain, store unchanged.
REQ-035 Assert reset with 3 queued entries in window -> STATUS reads 0x02 after reset, store unchanged by the queued entries.
REQ-036 CTRL=0x02 at line 100, enqueue while popping with FIFO full -> count stays 4, no overflow; addr_in=0x2000 -> data_out=0x00.
